// File: rtl/var_delay_line_pkg.sv
// rtl/var_delay_line_pkg.sv - shared DSP sample width and sample type for the delay/FIR blocks
package var_delay_line_pkg;

  localparam int SAMPLE_W  = 25;
  localparam int DL_MAX_DELAY = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/dl_ring_buf.sv
// rtl/dl_ring_buf.sv - DEPTH x WIDTH register file, one write port, one combinational read port
module dl_ring_buf #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/var_delay_line.sv
// rtl/var_delay_line.sv - runtime-programmable delay line (D = delay_sel + 1) over a ring buffer
module var_delay_line
  import var_delay_line_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int MAX_DELAY = DL_MAX_DELAY,
  parameter int AW        = $clog2(MAX_DELAY)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [AW-1:0]           i_delay_sel,
  input  logic signed [WIDTH-1:0] i_data_in,
  input  logic                    i_in_valid,
  output logic signed [WIDTH-1:0] o_data_out,
  output logic                    o_out_valid
);

  localparam logic [AW:0] FILL_MAX = (AW+1)'(MAX_DELAY);

  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_fill;
  logic [AW-1:0] r_d_reg;

  logic          w_flush;
  logic [AW:0]   w_fill_eff;
  logic [AW:0]   w_fill_next;
  logic [AW-1:0] w_rd_addr;
  logic          w_ready;
  logic [WIDTH:0] w_rd_data;

  // A delay change restarts the fill count so nothing written under the old delay can emerge.
  assign w_flush     = i_en && (i_delay_sel != r_d_reg);
  assign w_fill_eff  = w_flush ? '0 : r_fill;
  assign w_fill_next = w_flush ? (AW+1)'(1) :
                       ((r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1);
  assign w_rd_addr   = r_wr_ptr - i_delay_sel;
  assign w_ready     = ({1'b0, i_delay_sel} <= w_fill_eff);

  dl_ring_buf #(
    .WIDTH (WIDTH + 1),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ring_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (i_en),
    .i_waddr (r_wr_ptr),
    .i_wdata ({i_in_valid, i_data_in}),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_d_reg     <= '0;
      o_data_out  <= '0;
      o_out_valid <= 1'b0;
    end else if (i_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_fill   <= w_fill_next;
      r_d_reg  <= i_delay_sel;
      if (i_delay_sel == '0) begin
        o_data_out  <= i_data_in;
        o_out_valid <= i_in_valid;
      end else if (w_ready) begin
        o_data_out  <= w_rd_data[WIDTH-1:0];
        o_out_valid <= w_rd_data[WIDTH];
      end else begin
        o_data_out  <= '0;
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_var_delay_line.sv
// tb/tb_var_delay_line.sv - directed self-checking bench for var_delay_line
module tb_var_delay_line;

  logic               clk;
  logic               reset;
  logic               en;
  logic [3:0]         dsel;
  logic signed [24:0] din;
  logic               vin;
  logic signed [24:0] dout;
  logic               vout;

  int n_cmp;
  int n_err;

  logic [24:0] samp [0:255];
  logic [24:0] hold_d;
  logic        hold_v;
  logic [6:0]  pat;

  var_delay_line dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_en        (en),
    .i_delay_sel (dsel),
    .i_data_in   (din),
    .i_in_valid  (vin),
    .o_data_out  (dout),
    .o_out_valid (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    en    = 1'b0;
    dsel  = 4'd0;
    din   = '0;
    vin   = 1'b0;
    #3;
    chk("rst_data", dout, 25'd0);
    chk("rst_valid", {24'd0, vout}, 25'd0);

    // Impulse then 200 random samples at D=5 against a 5-deep reference history.
    do_reset();
    dsel = 4'd4;
    for (int n = 0; n < 208; n++) begin
      if (n == 0)      samp[n] = 25'h1FFFFFF;
      else if (n < 8)  samp[n] = 25'd0;
      else             samp[n] = 25'($urandom);
      en  = 1'b1;
      vin = 1'b1;
      din = samp[n];
      tick();
      chk($sformatf("d5_data_%0d", n), dout, (n < 4) ? 25'd0 : samp[n-4]);
      if (n < 10) chk($sformatf("d5_valid_%0d", n), {24'd0, vout}, (n < 4) ? 25'd0 : 25'd1);
    end

    // D=1 bypass.
    do_reset();
    dsel = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      en = 1'b1; vin = 1'b1; din = 25'(k);
      tick();
      chk($sformatf("d1_data_%0d", k), dout, 25'(k));
      chk($sformatf("d1_valid_%0d", k), {24'd0, vout}, 25'd1);
    end

    // D=16 wrap: the oldest entry is read just before it is overwritten.
    do_reset();
    dsel = 4'd15;
    for (int k = 1; k <= 40; k++) begin
      en = 1'b1; vin = 1'b1; din = 25'(k);
      tick();
      chk($sformatf("d16_data_%0d", k), dout, (k >= 16) ? 25'(k - 15) : 25'd0);
      chk($sformatf("d16_valid_%0d", k), {24'd0, vout}, (k >= 16) ? 25'd1 : 25'd0);
    end

    // D=8 -> D=3 at step 12.
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      en = 1'b1; vin = 1'b1; din = 25'(k);
      dsel = (k < 12) ? 4'd7 : 4'd2;
      tick();
      chk($sformatf("chg_data_%0d", k), dout,
          (k < 8) ? 25'd0 : (k < 12) ? 25'(k - 7) : (k < 14) ? 25'd0 : 25'(k - 2));
      chk($sformatf("chg_valid_%0d", k), {24'd0, vout},
          (k < 8) ? 25'd0 : (k < 12) ? 25'd1 : (k < 14) ? 25'd0 : 25'd1);
    end

    // D=4 with two 3-cycle stalls; delay_sel wiggles while stalled and must be ignored.
    do_reset();
    begin
      int m;
      m = 0;
      hold_d = '0;
      hold_v = 1'b0;
      for (int s = 0; s < 23; s++) begin
        en = !((s >= 6 && s < 9) || (s >= 14 && s < 17));
        if (en) begin
          m++;
          dsel = 4'd3; vin = 1'b1; din = 25'(m);
          hold_d = (m >= 4) ? 25'(m - 3) : 25'd0;
          hold_v = (m >= 4);
        end else begin
          dsel = 4'd9; vin = 1'b0; din = 25'h0ABCDE;
        end
        tick();
        chk($sformatf("stall_data_%0d", s), dout, hold_d);
        chk($sformatf("stall_valid_%0d", s), {24'd0, vout}, {24'd0, hold_v});
      end
    end

    // Async reset mid-stream, then restart at D=4.
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_data", dout, 25'd0);
    chk("midrst_valid", {24'd0, vout}, 25'd0);
    @(negedge clk);
    reset = 1'b0;
    dsel  = 4'd3;
    for (int k = 1; k <= 8; k++) begin
      en = 1'b1; vin = 1'b1; din = 25'(100 + k);
      tick();
      chk($sformatf("post_data_%0d", k), dout, (k >= 4) ? 25'(100 + k - 3) : 25'd0);
      chk($sformatf("post_valid_%0d", k), {24'd0, vout}, (k >= 4) ? 25'd1 : 25'd0);
    end

    // Valid pattern 1011001 and sign extremes at D=6.
    do_reset();
    dsel = 4'd5;
    pat  = 7'b1001101;
    for (int j = 0; j < 14; j++) begin
      if (j == 0)      samp[j] = 25'h1000000;
      else if (j == 1) samp[j] = 25'h0FFFFFF;
      else             samp[j] = 25'(j);
      en  = 1'b1;
      din = samp[j];
      vin = (j < 7) ? pat[j] : 1'b0;
      tick();
      chk($sformatf("vpat_data_%0d", j), dout, (j >= 5) ? samp[j-5] : 25'd0);
      chk($sformatf("vpat_valid_%0d", j), {24'd0, vout},
          (j >= 5 && j - 5 < 7) ? {24'd0, pat[j-5]} : 25'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
